flash_cmd_model: RTL

- Clocked, parametrised behavioural model of a parallel NOR flash (Intel-style command set) for board-level testbenches of the flash controller.
- Successor to the untimed store-only flash simulator.
- Adds a command state machine, status register, timed program/erase with NF_STS busy indication, block erase and bit-clearing program semantics.
- Sits outside the DUT on the NF_* pins; clk is the bench clock.

---
 rtl/flash_cmd_pkg.sv | 38 +++
 rtl/flash_busy_timer.sv | 30 +++
 rtl/flash_cmd_model.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_pkg.sv
// Shared constants for the NOR flash command model: command codes, status-register
// bit positions and the command-FSM state encoding.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
    localparam logic [7:0] CMD_READ_SR    = 8'h70;
    localparam logic [7:0] CMD_CLR_SR     = 8'h50;
    localparam logic [7:0] CMD_PROG       = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT   = 8'h10;
    localparam logic [7:0] CMD_ERASE      = 8'h20;
    localparam logic [7:0] CMD_CONFIRM    = 8'hD0;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_LOCK_ERR  = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_READ_ARRAY  = 3'd0;
    localparam state_t ST_READ_STATUS = 3'd1;
    localparam state_t ST_PROG_SETUP  = 3'd2;
    localparam state_t ST_ERASE_SETUP = 3'd3;
    localparam state_t ST_BUSY_PROG   = 3'd4;
    localparam state_t ST_BUSY_ERASE  = 3'd5;

    function automatic logic [7:0] sr_pack(input logic ready, input logic erase_err,
                                           input logic prog_err, input logic lock_err);
        logic [7:0] v;
        v               = '0;
        v[SR_READY]     = ready;
        v[SR_ERASE_ERR] = erase_err;
        v[SR_PROG_ERR]  = prog_err;
        v[SR_LOCK_ERR]  = lock_err;
        return v;
    endfunction

endpackage

// File: rtl/flash_busy_timer.sv
// Down-counting busy timer shared by program and erase: load a cycle count,
// stay busy until it reaches zero, pulse o_done in the last busy cycle.
module flash_busy_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_busy,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // done is high in the cycle whose closing edge takes the count to zero
    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/flash_cmd_model.sv
// Clocked behavioural model of a parallel NOR flash with Intel-style commands.
// Optional block-0 write protect via NF_WP is compiled in with FLASH_WP_EN.
//
// state          | meaning
// ST_READ_ARRAY  | reads return array contents
// ST_READ_STATUS | reads return the status register
// ST_PROG_SETUP  | next write supplies program address and data
// ST_ERASE_SETUP | next write must be 0xD0 to confirm a block erase
// ST_BUSY_PROG   | word program in progress, writes ignored
// ST_BUSY_ERASE  | block erase in progress, writes ignored
module flash_cmd_model
    import flash_cmd_pkg::*;
#(
    parameter int              AW           = 8,
    parameter int              DW           = 8,
    parameter int              BLK_AW       = 4,
    parameter int              PROG_CYCLES  = 4,
    parameter int              ERASE_CYCLES = 16,
    parameter logic [DW-1:0]   INIT_VAL     = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] NF_A,
    inout  wire  [DW-1:0] NF_D,
    input  logic          NF_CE,
    input  logic          NF_OE,
    input  logic          NF_WE,
    input  logic          NF_RP,
    input  logic          NF_WP,
    input  logic          NF_BYTE,
    output logic          NF_STS
);

    localparam int DEPTH     = 2 ** AW;
    localparam int BLK_WORDS = 2 ** BLK_AW;
    localparam int MAX_CYC   = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CW        = $clog2(MAX_CYC + 1);

    // array content survives reset; it is only set up at time zero
    logic [DW-1:0] r_mem [DEPTH] = '{default: INIT_VAL};

    logic          r_wr_act;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic [AW-1:0] r_tgt_a;
    logic [DW-1:0] r_tgt_d;
    logic          r_wp_hit;
    state_t        r_state;
    logic          r_sr_pe;
    logic          r_sr_ee;
    logic          r_sr_bl;

    logic          w_rst;
    logic          w_wr_ev;
    logic [7:0]    w_cmd;
    logic          w_wp_blk0;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_tmr_busy;
    logic          w_tmr_done;
    logic [7:0]    w_sr;
    logic [DW-1:0] w_rd_val;
    logic          w_unused_pins;

    assign w_rst         = rst || !NF_RP;
    assign w_unused_pins = ^{NF_BYTE, NF_WP};

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_wr_act <= 1'b0;
        end else begin
            r_wr_act <= !NF_CE && !NF_WE;
        end
        if (!NF_CE && !NF_WE) begin
            r_a <= NF_A;
            r_d <= NF_D;
        end
    end

    // a write lands on the first clock after WE returns high, using the held bus values
    assign w_wr_ev = r_wr_act && NF_WE && !NF_CE;
    assign w_cmd   = r_d[7:0];

`ifdef FLASH_WP_EN
    assign w_wp_blk0 = !NF_WP && (r_a[AW-1:BLK_AW] == '0);
`else
    assign w_wp_blk0 = 1'b0;
`endif

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_wr_ev) begin
            if (r_state == ST_PROG_SETUP) begin
                w_load     = 1'b1;
                w_load_val = w_wp_blk0 ? CW'(1) : CW'(PROG_CYCLES);
            end else if (r_state == ST_ERASE_SETUP && w_cmd == CMD_CONFIRM) begin
                w_load     = 1'b1;
                w_load_val = w_wp_blk0 ? CW'(1) : CW'(ERASE_CYCLES);
            end
        end
    end

    flash_busy_timer #(
        .CW (CW)
    ) u_busy_timer (
        .clk        (clk),
        .i_rst      (w_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_busy     (w_tmr_busy),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state  <= ST_READ_ARRAY;
            r_sr_pe  <= 1'b0;
            r_sr_ee  <= 1'b0;
            r_sr_bl  <= 1'b0;
            r_wp_hit <= 1'b0;
        end else begin
            case (r_state)
                ST_READ_ARRAY, ST_READ_STATUS: begin
                    if (w_wr_ev) begin
                        case (w_cmd)
                            CMD_READ_ARRAY: r_state <= ST_READ_ARRAY;
                            CMD_READ_SR:    r_state <= ST_READ_STATUS;
                            CMD_CLR_SR: begin
                                r_sr_pe <= 1'b0;
                                r_sr_ee <= 1'b0;
                                r_sr_bl <= 1'b0;
                            end
                            CMD_PROG, CMD_PROG_ALT: r_state <= ST_PROG_SETUP;
                            CMD_ERASE:              r_state <= ST_ERASE_SETUP;
                            default: ;
                        endcase
                    end
                end
                ST_PROG_SETUP: begin
                    if (w_wr_ev) begin
                        r_state  <= ST_BUSY_PROG;
                        r_tgt_a  <= r_a;
                        r_tgt_d  <= r_d;
                        r_wp_hit <= w_wp_blk0;
                    end
                end
                ST_ERASE_SETUP: begin
                    if (w_wr_ev) begin
                        if (w_cmd == CMD_CONFIRM) begin
                            r_state  <= ST_BUSY_ERASE;
                            r_tgt_a  <= r_a;
                            r_wp_hit <= w_wp_blk0;
                        end else begin
                            r_sr_pe <= 1'b1;
                            r_sr_ee <= 1'b1;
                            r_state <= ST_READ_STATUS;
                        end
                    end
                end
                ST_BUSY_PROG: begin
                    if (w_tmr_done) begin
                        r_state <= ST_READ_STATUS;
                        if (r_wp_hit) begin
                            r_sr_bl <= 1'b1;
                            r_sr_pe <= 1'b1;
                        end
                    end
                end
                ST_BUSY_ERASE: begin
                    if (w_tmr_done) begin
                        r_state <= ST_READ_STATUS;
                        if (r_wp_hit) begin
                            r_sr_bl <= 1'b1;
                            r_sr_ee <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_READ_ARRAY;
            endcase
        end
    end

    // commit on the same edge the timer expires; a reset on that edge aborts it
    always_ff @(posedge clk) begin
        if (!w_rst && w_tmr_done && !r_wp_hit) begin
            if (r_state == ST_BUSY_PROG) begin
                r_mem[r_tgt_a] <= r_mem[r_tgt_a] & r_tgt_d;
            end else if (r_state == ST_BUSY_ERASE) begin
                for (int i = 0; i < BLK_WORDS; i++) begin
                    r_mem[{r_tgt_a[AW-1:BLK_AW], BLK_AW'(i)}] <= '1;
                end
            end
        end
    end

    assign w_sr     = sr_pack(!w_tmr_busy, r_sr_ee, r_sr_pe, r_sr_bl);
    assign w_rd_val = (r_state == ST_READ_ARRAY) ? r_mem[NF_A] : DW'(w_sr);
    assign NF_D     = (!NF_CE && !NF_OE && NF_WE) ? w_rd_val : 'z;
    assign NF_STS   = !w_tmr_busy;

endmodule
